// File: rtl/fast_exp_pkg.sv
// Shared types for the fast_exp square-and-multiply engine.
package fast_exp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    MODE_PLAIN = 1'b0,
    MODE_MOD   = 1'b1
  } mode_t;

endpackage

// File: rtl/fast_exp_mulmod.sv
// Combinational WIDTH x WIDTH multiplier with optional reduction modulo m.
// Also reports whether the full product spilled above the low WIDTH bits.
module fast_exp_mulmod
  import fast_exp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  input  mode_t            mode,
  output logic [WIDTH-1:0] p,
  output logic             hi_nz
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] rem;

  always_comb begin
    prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    // m == 0 only reaches here in the error case, where the output is discarded.
    rem   = (m != '0) ? (prod % {{WIDTH{1'b0}}, m}) : '0;
    hi_nz = |prod[2*WIDTH-1:WIDTH];
    p     = (mode == MODE_MOD) ? rem[WIDTH-1:0] : prod[WIDTH-1:0];
  end

endmodule

// File: rtl/fast_exp_param.sv
// Square-and-multiply exponentiator, one exponent bit per cycle, plain or modular.
// Optional plain-mode overflow flag enabled by defining FAST_EXP_OVF_DETECT_EN.
module fast_exp_param
  import fast_exp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 ready,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 err,
  output logic                 ovf
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [EXP_WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [WIDTH-1:0]     ax_p, xx_p;
  logic                 ax_hi, xx_hi;
  logic                 accept;
  logic                 mod_err;
  logic                 step_en;

  fast_exp_mulmod #(.WIDTH(WIDTH)) u_mul_ax (
    .a     (a_q),
    .b     (x_q),
    .m     (m_q),
    .mode  (mode_q),
    .p     (ax_p),
    .hi_nz (ax_hi)
  );

  fast_exp_mulmod #(.WIDTH(WIDTH)) u_mul_xx (
    .a     (x_q),
    .b     (x_q),
    .m     (m_q),
    .mode  (mode_q),
    .p     (xx_p),
    .hi_nz (xx_hi)
  );

  always_comb begin
    accept  = (state_q == IDLE) && start;
    mod_err = (mode_q == MODE_MOD) && (m_q == '0);
    step_en = (state_q == BUSY) && !mod_err && (n_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_PLAIN;
      m_q      <= '0;
      a_q      <= '0;
      x_q      <= '0;
      n_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      m_q      <= m_d;
      a_q      <= a_d;
      x_q      <= x_d;
      n_q      <= n_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    m_d      = m_q;
    a_d      = a_q;
    x_d      = x_q;
    n_d      = n_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d = mode_t'(mode);
          m_d    = modulus;
          n_d    = exp;
          err_d  = 1'b0;
          if (mode_t'(mode) == MODE_MOD) begin
            // Start from 1 mod m and base mod m so every operand stays reduced.
            a_d = (modulus == ONE) ? '0 : ONE;
            x_d = (modulus != '0) ? (base % modulus) : '0;
          end else begin
            a_d = ONE;
            x_d = base;
          end
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mod_err) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (n_q == '0) begin
          result_d = a_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          if (n_q[0]) a_d = ax_p;
          x_d = xx_p;
          n_d = n_q >> 1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready  = (state_q == IDLE);
    done   = done_q;
    result = result_q;
    err    = err_q;
  end

`ifdef FAST_EXP_OVF_DETECT_EN
  logic ovf_q, ovf_d;

  // Squaring overflow only matters while later exponent bits still consume x.
  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = 1'b0;
    end else if (step_en && (mode_q == MODE_PLAIN)) begin
      if ((n_q[0] && ax_hi) || (xx_hi && ((n_q >> 1) != '0))) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_inputs;
  assign unused_ovf_inputs = ax_hi ^ xx_hi ^ step_en;
  assign ovf = 1'b0;
`endif

endmodule
